key_scheduler: RTL and testbench
================================

Name: key_scheduler

Overview:
Sits between the per-button debounce stages and the clock's time-setting logic. Takes NKEYS already-debounced key levels and grants ownership to one key at a time. It issues one command per press, then auto-repeat commands while the key is held. Commands leave through a valid/ready handshake, so the consumer can stall without losing a command.

Parameters:
NKEYS, 4, number of debounced key inputs.
KW, 2, width of the key index; must satisfy 2**KW >= NKEYS.
CW, 26, width of the hold/repeat counter.
HOLD_DLY, 50000000, cycles from first command to first repeat (1 s at 50 MHz).
RPT_DLY, 10000000, cycles between successive repeats (200 ms at 50 MHz); must be >= 1.

Ports:
clk  in  1  system clock; all state is updated on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
clean  in  NKEYS  debounced key levels, 1 = pressed; synchronous to clk.
cmd_ready  in  1  consumer accepts the command this cycle.
cmd_valid  out  1  command pending.
cmd_key  out  KW  index of the key that owns the command.
cmd_rpt  out  1  0 = initial press, 1 = auto-repeat.
busy  out  1  a key currently owns the scheduler.

Behaviour:
- Reset (async assert, rst_n=0):
  - state=IDLE; cmd_valid=0, cmd_key=0, cmd_rpt=0, busy=0; counter=0.
  - The edge-detect history register is loaded with all 1s. Keys held through reset therefore never fire until released and pressed again.
- Edge detect: rise[i] = clean[i] & ~prev[i]. prev is updated every cycle in every state.
- IDLE:
  - If any rise bit is set, the lowest set index k wins.
  - Next cycle: state=PEND, cmd_valid=1, cmd_key=k, cmd_rpt=0, busy=1, counter=0.
  - Rises on other keys in the same cycle are dropped, not queued.
- PEND:
  - cmd_valid is held and cmd_key/cmd_rpt stay stable until cmd_ready=1.
  - On the accept cycle, cmd_valid drops next cycle.
  - If clean[owner]=1, go to HOLD and clear the counter; otherwise go to IDLE with busy=0.
  - The owner level is sampled in the accept cycle. A release during the stall does not cancel the pending command.
- HOLD:
  - The counter increments every cycle while clean[owner]=1.
  - First repeat: when counter reaches HOLD_DLY-1 and no repeat has been issued yet, go to PEND with cmd_rpt=1 and counter=0.
  - Later repeats: the threshold is RPT_DLY-1 once at least one repeat has been issued (internal flag, cleared on entry from IDLE).
  - clean[owner]=0 at any point: go to IDLE, busy=0, and no command is issued that cycle.
- The counter is frozen in PEND, so a stalled consumer delays repeats rather than accumulating them. At most one command is ever outstanding.
- Non-owner keys are ignored while busy=1. Their prev bits still track, so a key already held when the owner releases does not fire.
- Boundaries:
  - IDLE->PEND latency is 1 cycle after the rising edge of clean.
  - cmd_ready asserted while cmd_valid=0 is ignored.
  - Owner release and repeat threshold in the same HOLD cycle: release wins, no command.
- The counter saturates rather than wrapping; HOLD_DLY and RPT_DLY must be <= 2**CW-1.
- All outputs are registered.

Test Plan:
- Single tap (HOLD_DLY=20, RPT_DLY=5, cmd_ready tied 1): clean=0001 for 3 cycles -> exactly one cmd_valid pulse, cmd_key=0, cmd_rpt=0, arriving 1 cycle after the clean rise; busy=0 after release.
- Hold: clean[2] held for 60 cycles -> first command cmd_rpt=0, then repeats at +20 and every +5 cycles thereafter, each with cmd_rpt=1, cmd_key=2; 9 commands total. After release: no further commands.
- Simultaneous press: clean 0000->1010 in one cycle -> a command for key 1 only. Release key 1 while key 3 is still held -> no command for key 3; re-press key 3 -> command with cmd_key=3.
- Backpressure: hold key 0 with cmd_ready=0 for 50 cycles -> cmd_valid stays 1 with cmd_key=0, cmd_rpt=0 throughout. Release key 0, then raise cmd_ready -> accepted once, then IDLE with no repeat.
- Reset mid-operation: assert rst_n=0 during PEND -> cmd_valid=0 and busy=0 immediately, without waiting for a clock edge. Deassert with clean[1]=1 still held -> no command until key 1 is released and re-pressed.
- Threshold/release collision: release the owner exactly on the cycle the counter hits HOLD_DLY-1 -> no repeat is issued, state=IDLE, busy=0.

Source files
------------

// File: rtl/key_scheduler_if.sv
// Command handshake between the key scheduler and the time-setting logic.
// The scheduler is the master; the consumer drives cmd_ready.
interface key_scheduler_if #(
    parameter int KW = 2
);
    logic          cmd_valid;
    logic [KW-1:0] cmd_key;
    logic          cmd_rpt;
    logic          cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_key,
        output cmd_rpt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_key,
        input  cmd_rpt,
        output cmd_ready
    );
endinterface

// File: rtl/key_scheduler.sv
// Grants one debounced key at a time; emits a press command, then
// auto-repeats while held, through a stallable valid/ready handshake.
module key_scheduler #(
    parameter int NKEYS    = 4,
    parameter int KW       = 2,
    parameter int CW       = 26,
    parameter int HOLD_DLY = 50000000,
    parameter int RPT_DLY  = 10000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NKEYS-1:0] clean,
    key_scheduler_if.master  cmd,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Thresholds are compared against the post-increment count, so the
    // spacing between command starts equals the configured delay.
    localparam logic [CW:0] HOLD_THR = (CW+1)'(HOLD_DLY - 1);
    localparam logic [CW:0] RPT_THR  = (CW+1)'(RPT_DLY - 1);

    state_t           state;
    logic [NKEYS-1:0] prev;
    logic [CW-1:0]    cnt;
    logic             rpt_seen;

    logic [NKEYS-1:0] rise;
    logic             any_rise;
    logic [KW-1:0]    win;
    logic             own_lvl;
    logic [CW:0]      cnt_nx;
    logic [CW:0]      thr;
    logic             fire;

    assign rise     = clean & ~prev;
    assign any_rise = |rise;
    assign own_lvl  = clean[cmd.cmd_key];
    assign cnt_nx   = {1'b0, cnt} + (CW+1)'(1);
    assign thr      = rpt_seen ? RPT_THR : HOLD_THR;
    assign fire     = (cnt_nx >= thr);

    // Lowest-index rising key wins arbitration.
    always_comb begin
        win = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (rise[i]) win = KW'(i);
        end
    end

    // Scheduler FSM with registered command outputs and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            prev          <= '1;
            cnt           <= '0;
            rpt_seen      <= 1'b0;
            busy          <= 1'b0;
            cmd.cmd_valid <= 1'b0;
            cmd.cmd_key   <= '0;
            cmd.cmd_rpt   <= 1'b0;
        end else begin
            prev <= clean;
            unique case (state)
                IDLE: begin
                    if (any_rise) begin
                        state         <= PEND;
                        cmd.cmd_valid <= 1'b1;
                        cmd.cmd_key   <= win;
                        cmd.cmd_rpt   <= 1'b0;
                        busy          <= 1'b1;
                        cnt           <= '0;
                        rpt_seen      <= 1'b0;
                    end
                end
                PEND: begin
                    if (cmd.cmd_ready) begin
                        cmd.cmd_valid <= 1'b0;
                        if (own_lvl) begin
                            state <= HOLD;
                            cnt   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (!own_lvl) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fire) begin
                        state         <= PEND;
                        cmd.cmd_valid <= 1'b1;
                        cmd.cmd_rpt   <= 1'b1;
                        cnt           <= '0;
                        rpt_seen      <= 1'b1;
                    end else if (!(&cnt)) begin
                        cnt <= cnt_nx[CW-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_scheduler.sv
// Bench for key_scheduler: directed scenarios plus random key/ready
// traffic, checked every cycle against a delay-based behavioural model.
module tb_key_scheduler;

    localparam int NK   = 4;
    localparam int HOLD = 20;
    localparam int RPT  = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] clean = '0;
    logic          busy;

    key_scheduler_if #(.KW(2)) bus ();

    key_scheduler #(
        .NKEYS(NK), .KW(2), .CW(8),
        .HOLD_DLY(HOLD), .RPT_DLY(RPT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clean(clean),
        .cmd(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_no = 0;

    typedef struct {
        int cy;
        int key;
        int rpt;
    } acc_t;
    acc_t log_q[$];

    // Behavioural model: ownership plus "cycles left until next command".
    bit          m_valid = 0;
    int          m_key   = 0;
    bit          m_rpt   = 0;
    bit          m_busy  = 0;
    bit [NK-1:0] m_prev  = '1;
    int          m_wait  = 0;
    int          m_reps  = 0;
    bit [NK-1:0] m_r;
    int          m_k;

    always @(posedge clk) cyc_no++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_key = 0; m_rpt = 0; m_busy = 0;
            m_prev = '1; m_wait = 0; m_reps = 0;
        end else begin
            m_r = clean & ~m_prev;
            m_prev = clean;
            if (!m_busy) begin
                if (m_r != 0) begin
                    m_k = -1;
                    for (int i = 0; i < NK; i++)
                        if (m_r[i] && m_k < 0) m_k = i;
                    m_valid = 1; m_key = m_k; m_rpt = 0;
                    m_busy = 1; m_reps = 0;
                end
            end else if (m_valid) begin
                if (bus.cmd_ready) begin
                    m_valid = 0;
                    if (clean[m_key]) begin
                        m_wait = (m_reps > 0 ? RPT : HOLD) - 1;
                        if (m_wait < 1) m_wait = 1;
                    end else begin
                        m_busy = 0;
                    end
                end
            end else if (!clean[m_key]) begin
                m_busy = 0;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_valid = 1; m_rpt = 1; m_reps++;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        total++;
        if (bus.cmd_valid !== m_valid || busy !== m_busy ||
            (m_valid && (int'(bus.cmd_key) != m_key ||
                         bus.cmd_rpt !== m_rpt))) begin
            bad++;
            $display("FAIL model cyc=%0d got v=%b k=%0d r=%b b=%b want v=%b k=%0d r=%b b=%b",
                     cyc_no, bus.cmd_valid, bus.cmd_key, bus.cmd_rpt, busy,
                     m_valid, m_key, m_rpt, m_busy);
        end
        if (rst_n && bus.cmd_valid && bus.cmd_ready)
            log_q.push_back('{cyc_no, int'(bus.cmd_key), int'(bus.cmd_rpt)});
    end

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int t0;

    initial begin
        bus.cmd_ready = 1'b0;
        cyc(3);
        chk("rst_valid", int'(bus.cmd_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_key", int'(bus.cmd_key), 0);
        chk("rst_rpt", int'(bus.cmd_rpt), 0);
        rst_n = 1'b1;
        cyc(2);

        // Single tap
        bus.cmd_ready = 1'b1;
        log_q.delete();
        t0 = cyc_no;
        clean = 4'b0001;
        cyc(3);
        clean = 4'b0000;
        cyc(5);
        chk("tap_count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            chk("tap_key", log_q[0].key, 0);
            chk("tap_rpt", log_q[0].rpt, 0);
            chk("tap_latency", log_q[0].cy - t0, 1);
        end
        chk("tap_busy", int'(busy), 0);

        // Hold with auto-repeat
        log_q.delete();
        clean = 4'b0100;
        cyc(60);
        clean = 4'b0000;
        cyc(10);
        chk("hold_count", log_q.size(), 9);
        if (log_q.size() >= 9) begin
            chk("hold_key0", log_q[0].key, 2);
            chk("hold_rpt0", log_q[0].rpt, 0);
            chk("hold_gap1", log_q[1].cy - log_q[0].cy, HOLD);
            chk("hold_gap2", log_q[2].cy - log_q[1].cy, RPT);
            chk("hold_gap8", log_q[8].cy - log_q[7].cy, RPT);
            chk("hold_rpt1", log_q[1].rpt, 1);
            chk("hold_key8", log_q[8].key, 2);
        end

        // Simultaneous press, leftover held key, re-press
        log_q.delete();
        clean = 4'b1010;
        cyc(3);
        clean = 4'b1000;
        cyc(5);
        chk("sim_count", log_q.size(), 1);
        if (log_q.size() > 0) chk("sim_key", log_q[0].key, 1);
        chk("sim_busy", int'(busy), 0);
        clean = 4'b0000;
        cyc(2);
        clean = 4'b1000;
        cyc(2);
        clean = 4'b0000;
        cyc(3);
        chk("repress_count", log_q.size(), 2);
        if (log_q.size() > 1) chk("repress_key", log_q[1].key, 3);

        // Backpressure
        log_q.delete();
        bus.cmd_ready = 1'b0;
        clean = 4'b0001;
        cyc(50);
        chk("bp_valid", int'(bus.cmd_valid), 1);
        chk("bp_key", int'(bus.cmd_key), 0);
        chk("bp_rpt", int'(bus.cmd_rpt), 0);
        clean = 4'b0000;
        cyc(2);
        bus.cmd_ready = 1'b1;
        cyc(6);
        chk("bp_count", log_q.size(), 1);
        chk("bp_busy", int'(busy), 0);

        // Reset while pending
        log_q.delete();
        bus.cmd_ready = 1'b0;
        clean = 4'b0010;
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(bus.cmd_valid), 0);
        chk("arst_busy", int'(busy), 0);
        cyc(2);
        rst_n = 1'b1;
        bus.cmd_ready = 1'b1;
        cyc(20);
        chk("arst_nocmd", log_q.size(), 0);
        clean = 4'b0000;
        cyc(2);
        clean = 4'b0010;
        cyc(2);
        clean = 4'b0000;
        cyc(3);
        chk("arst_repress", log_q.size(), 1);
        if (log_q.size() > 0) chk("arst_key", log_q[0].key, 1);

        // Release on the threshold cycle
        log_q.delete();
        clean = 4'b0100;
        cyc(HOLD);
        clean = 4'b0000;
        cyc(5);
        chk("coll_count", log_q.size(), 1);
        chk("coll_busy", int'(busy), 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0)
                clean[$urandom_range(0, NK - 1)] ^= 1'b1;
            bus.cmd_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        clean = '0;
        bus.cmd_ready = 1'b1;
        cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
